// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: hazard detection and operand forwarding for the pipelined MIPS core.
// It keeps a shadow pipeline of in-flight producers, picks a forwarding source for
// every read port of the ID instruction, and stalls ID until load data is reachable.
// Optional feature: define HAZ_PERF_CNT_EN to add the 32-bit stall_cnt output.
module hazard_fwd_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int NSTG     = 3,
    parameter int NPORT    = 2,
    parameter int LOAD_STG = 2,
    parameter int SEL_W    = $clog2(NSTG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [NPORT*ADDR_W-1:0] id_src,
    input  logic [ADDR_W-1:0]       id_dest,
    input  logic                    id_reg_write,
    input  logic                    id_is_load,
    input  logic                    flush,
    output logic                    stall,
    output logic [NPORT*SEL_W-1:0]  fwd_sel,
    output logic [NSTG-1:0]         stg_valid
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    logic [NSTG-1:0]        vld_q, vld_d;
    logic [NSTG-1:0]        wr_q, wr_d;
    logic [NSTG-1:0]        ld_q, ld_d;
    logic [ADDR_W-1:0]      dest_q [NSTG];
    logic [ADDR_W-1:0]      dest_d [NSTG];
    logic [NPORT*SEL_W-1:0] fwd_sel_q, fwd_sel_d;
    logic [NPORT*SEL_W-1:0] sel_calc;
    logic [NPORT-1:0]       hazard;
    logic [NPORT-1:0]       found;
    logic                   issue;

    // Per port, find the youngest matching producer; forward it if its data is
    // already in a pipeline register, otherwise flag a hazard. The last stage is
    // skipped because the register file write lands before the consumer reads it.
    always_comb begin
        sel_calc = '0;
        hazard   = '0;
        found    = '0;
        for (int p = 0; p < NPORT; p++) begin
            for (int k = 0; k < NSTG - 1; k++) begin
                if (!found[p] && vld_q[k] && wr_q[k] && (dest_q[k] != '0) &&
                    (dest_q[k] == id_src[p*ADDR_W +: ADDR_W])) begin
                    found[p] = 1'b1;
                    if (!ld_q[k] || (k + 1 >= LOAD_STG)) begin
                        sel_calc[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    end else begin
                        hazard[p] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall = id_valid & ~flush & (|hazard);
    assign issue = id_valid & ~flush & ~stall;

    // Advance the shadow pipeline one stage; stage 0 takes the issued instruction
    // or a bubble, and the selects are zeroed whenever nothing real enters EX.
    always_comb begin
        vld_d[0]  = issue;
        wr_d[0]   = id_reg_write;
        ld_d[0]   = id_is_load;
        dest_d[0] = id_dest;
        for (int k = 1; k < NSTG; k++) begin
            vld_d[k]  = vld_q[k-1];
            wr_d[k]   = wr_q[k-1];
            ld_d[k]   = ld_q[k-1];
            dest_d[k] = dest_q[k-1];
        end
        fwd_sel_d = issue ? sel_calc : '0;
    end

    // Stage entries and EX-aligned forwarding selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            wr_q      <= '0;
            ld_q      <= '0;
            fwd_sel_q <= '0;
            for (int k = 0; k < NSTG; k++) begin
                dest_q[k] <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            wr_q      <= wr_d;
            ld_q      <= ld_d;
            fwd_sel_q <= fwd_sel_d;
            for (int k = 0; k < NSTG; k++) begin
                dest_q[k] <= dest_d[k];
            end
        end
    end

    assign fwd_sel   = fwd_sel_q;
    assign stg_valid = vld_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count stalled cycles; wraps naturally at 32 bits and ignores flush.
    always_comb begin
        stall_cnt_d = stall ? (stall_cnt_q + 32'd1) : stall_cnt_q;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Testbench for hazard_fwd_ctrl: a default instance (NSTG=3, LOAD_STG=2) and a
// deeper instance (NSTG=4, LOAD_STG=3) driven with directed vectors. Expected
// fwd_sel values go into per-instance queues and are popped by monitors whenever
// the DUT shows an occupied EX stage.
module tb_hazard_fwd_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // Clock generator, 10 time-unit period.
   always #5 clk = ~clk;

   logic       a_valid = 1'b0, a_wr = 1'b0, a_ld = 1'b0, a_flush = 1'b0;
   logic [9:0] a_src = '0;
   logic [4:0] a_dest = '0;
   logic       a_stall;
   logic [3:0] a_fwd;
   logic [2:0] a_stg;

   logic       b_valid = 1'b0, b_wr = 1'b0, b_ld = 1'b0, b_flush = 1'b0;
   logic [9:0] b_src = '0;
   logic [4:0] b_dest = '0;
   logic       b_stall;
   logic [3:0] b_fwd;
   logic [3:0] b_stg;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] a_stall_cnt, b_stall_cnt;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int qa[$];
   int qb[$];

   hazard_fwd_ctrl dut_a (
      .clk(clk), .rst_n(rst_n), .id_valid(a_valid), .id_src(a_src),
      .id_dest(a_dest), .id_reg_write(a_wr), .id_is_load(a_ld), .flush(a_flush),
      .stall(a_stall), .fwd_sel(a_fwd), .stg_valid(a_stg)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt(a_stall_cnt)
`endif
   );

   hazard_fwd_ctrl #(.NSTG(4), .LOAD_STG(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_valid(b_valid), .id_src(b_src),
      .id_dest(b_dest), .id_reg_write(b_wr), .id_is_load(b_ld), .flush(b_flush),
      .stall(b_stall), .fwd_sel(b_fwd), .stg_valid(b_stg)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt(b_stall_cnt)
`endif
   );

   // Single comparison point: counts and reports every check.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one ID-stage vector to instance 'which' at the falling edge, check the
   // combinational stall and current occupancy, and queue the expected selects.
   task automatic applyStimulus(input int which, input logic v, input int s0, input int s1,
                                input int d, input logic wr, input logic ld, input logic fl,
                                input logic ex_stall, input int ex_stg, input int ex_s0,
                                input int ex_s1, input string tag);
      @(negedge clk);
      if (which == 0) begin
         a_valid = v; a_src = {5'(s1), 5'(s0)}; a_dest = 5'(d);
         a_wr = wr; a_ld = ld; a_flush = fl;
      end else begin
         b_valid = v; b_src = {5'(s1), 5'(s0)}; b_dest = 5'(d);
         b_wr = wr; b_ld = ld; b_flush = fl;
      end
      #1;
      if (which == 0) begin
         checkOutput({tag, " stall"}, a_stall, ex_stall);
         checkOutput({tag, " stg_valid"}, a_stg, ex_stg);
         if (v && !fl && !ex_stall) qa.push_back(ex_s1 * 4 + ex_s0);
      end else begin
         checkOutput({tag, " stall"}, b_stall, ex_stall);
         checkOutput({tag, " stg_valid"}, b_stg, ex_stg);
         if (v && !fl && !ex_stall) qb.push_back(ex_s1 * 4 + ex_s0);
      end
   endtask

   // Monitor for instance A: occupied EX pops an expectation, a bubble must read 0.
   always @(negedge clk) begin
      if (a_stg[0]) begin
         if (qa.size() == 0) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL sb_a: EX occupied, got fwd %0d, expected no entry", a_fwd);
         end else begin
            checkOutput("sb_a fwd_sel", a_fwd, qa.pop_front());
         end
      end else begin
         checkOutput("sb_a bubble fwd_sel", a_fwd, 0);
      end
   end

   // Monitor for instance B.
   always @(negedge clk) begin
      if (b_stg[0]) begin
         if (qb.size() == 0) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL sb_b: EX occupied, got fwd %0d, expected no entry", b_fwd);
         end else begin
            checkOutput("sb_b fwd_sel", b_fwd, qb.pop_front());
         end
      end else begin
         checkOutput("sb_b bubble fwd_sel", b_fwd, 0);
      end
   end

   // Runaway guard.
   initial begin
      #20000;
      n_fail++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      #2;
      checkOutput("reset stall", a_stall, 0);
      checkOutput("reset stg_valid", a_stg, 0);
      checkOutput("reset fwd_sel", a_fwd, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU chain and youngest-wins / $zero cases on instance A.
      applyStimulus(0, 1, 1, 2, 3, 1, 0, 0, 0, 3'b000, 0, 0, "add $3");
      applyStimulus(0, 1, 3, 0, 6, 1, 0, 0, 0, 3'b001, 1, 0, "sub uses $3");
      applyStimulus(0, 1, 3, 6, 8, 1, 0, 0, 0, 3'b011, 2, 1, "and uses $3,$6");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, "nop1");
      applyStimulus(0, 1, 0, 0, 4, 1, 0, 0, 0, 3'b110, 0, 0, "A writes $4");
      applyStimulus(0, 1, 0, 0, 4, 1, 0, 0, 0, 3'b101, 0, 0, "B writes $4");
      applyStimulus(0, 1, 4, 4, 9, 1, 0, 0, 0, 3'b011, 1, 1, "C youngest wins");
      applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0, 3'b111, 0, 0, "D load to $0");
      applyStimulus(0, 1, 0, 9, 10, 1, 0, 0, 0, 3'b111, 0, 2, "E reads $0,$9");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, "nop2");

      // Load-use on port 1: one stall cycle then select 2.
      applyStimulus(0, 1, 1, 0, 5, 1, 1, 0, 0, 3'b110, 0, 0, "lw $5");
      applyStimulus(0, 1, 0, 5, 11, 1, 0, 0, 1, 3'b101, 0, 0, "F stalls");
      applyStimulus(0, 1, 0, 5, 11, 1, 0, 0, 0, 3'b010, 0, 2, "F issues");

      // Flush of a stalled dependent: no stall, the load keeps moving.
      applyStimulus(0, 1, 0, 0, 12, 1, 1, 0, 0, 3'b101, 0, 0, "lw $12");
      applyStimulus(0, 1, 12, 0, 13, 1, 0, 1, 0, 3'b011, 0, 0, "G flushed");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b110, 0, 0, "after flush");

      // Reset while stalled.
      applyStimulus(0, 1, 0, 0, 13, 1, 1, 0, 0, 3'b100, 0, 0, "lw $13");
      applyStimulus(0, 1, 13, 0, 14, 1, 0, 0, 1, 3'b001, 0, 0, "I stalls");
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mid reset stall", a_stall, 0);
      checkOutput("mid reset stg_valid", a_stg, 0);
      checkOutput("mid reset fwd_sel", a_fwd, 0);
      a_valid = 1'b0; a_src = '0; a_dest = '0; a_wr = 1'b0; a_ld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 1, 13, 0, 15, 1, 0, 0, 0, 3'b000, 0, 0, "J after reset");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, "nop3");

      // Instance B: three load-use pairs, two stall cycles each, then select 3.
      for (int it = 0; it < 3; it++) begin
         applyStimulus(1, 1, 0, 0, 5, 1, 1, 0, 0, (it == 0) ? 4'b0000 : 4'b1001, 0, 0, "B lw $5");
         applyStimulus(1, 1, 0, 5, 6, 1, 0, 0, 1, (it == 0) ? 4'b0001 : 4'b0011, 0, 0, "B stall1");
         applyStimulus(1, 1, 0, 5, 6, 1, 0, 0, 1, (it == 0) ? 4'b0010 : 4'b0110, 0, 0, "B stall2");
         applyStimulus(1, 1, 0, 5, 6, 1, 0, 0, 0, (it == 0) ? 4'b0100 : 4'b1100, 0, 3, "B issue");
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1001, 0, 0, "B nop1");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0, "B nop2");

      repeat (6) @(negedge clk);
      #1;
      checkOutput("sb_a drained", qa.size(), 0);
      checkOutput("sb_b drained", qb.size(), 0);
`ifdef HAZ_PERF_CNT_EN
      checkOutput("a stall_cnt", a_stall_cnt, 0);
      checkOutput("b stall_cnt", b_stall_cnt, 6);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
